// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register chain with valid/ready handshake, flush and occupancy count.
// Define PIPE_ELASTIC_SKID_EN to turn each slot into a 2-entry skid buffer with registered ready.
module pipe_elastic_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 1,
  parameter logic [31:0] NOP_VALUE = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           flush,
  output logic [$clog2(2*DEPTH+1)-1:0]   count
);

  localparam int unsigned    CntW   = $clog2(2*DEPTH+1);
  localparam logic [WIDTH-1:0] NopVal = WIDTH'(NOP_VALUE);

  logic [DEPTH-1:0] main_v_q, main_v_d;
  logic [WIDTH-1:0] main_d_q [DEPTH];
  logic [WIDTH-1:0] main_d_d [DEPTH];

  // Per-slot view of what the upstream side offers and whether downstream takes.
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] dn_rdy;

  logic             in_hs, out_hs;
  logic [CntW-1:0]  count_q, count_d;

  assign out_valid = main_v_q[DEPTH-1];
  assign out_data  = main_d_q[DEPTH-1];
  assign count     = count_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    src_v    = '0;
    src_v[0] = in_hs;
    src_d[0] = in_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      src_v[k] = main_v_q[k-1];
      src_d[k] = main_d_q[k-1];
    end
  end

`ifdef PIPE_ELASTIC_SKID_EN
  logic [DEPTH-1:0] skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_d_q [DEPTH];
  logic [WIDTH-1:0] skid_d_d [DEPTH];
  logic [DEPTH-1:0] acc;

  // A slot's ready is simply "skid register empty", so it comes straight from a flop.
  always_comb begin
    dn_rdy          = '0;
    dn_rdy[DEPTH-1] = out_ready;
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      dn_rdy[k] = ~skid_v_q[k+1];
    end
  end

  assign in_ready = ~skid_v_q[0] & ~flush & ~rst;

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    acc      = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      acc[k] = src_v[k] & ~skid_v_q[k];
      if (!main_v_q[k] || dn_rdy[k]) begin
        if (skid_v_q[k]) begin
          main_v_d[k] = 1'b1;
          main_d_d[k] = skid_d_q[k];
          skid_v_d[k] = 1'b0;
          skid_d_d[k] = NopVal;
        end else if (acc[k]) begin
          main_v_d[k] = 1'b1;
          main_d_d[k] = src_d[k];
        end else begin
          main_v_d[k] = 1'b0;
          main_d_d[k] = NopVal;
        end
      end else if (acc[k]) begin
        skid_v_d[k] = 1'b1;
        skid_d_d[k] = src_d[k];
      end
    end
  end
`else
  logic [DEPTH-1:0] rdy;

  // Ready ripples back from out_ready; any empty slot makes everything behind it ready.
  always_comb begin
    rdy             = '0;
    dn_rdy          = '0;
    dn_rdy[DEPTH-1] = out_ready;
    rdy[DEPTH-1]    = ~main_v_q[DEPTH-1] | out_ready;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      dn_rdy[k] = rdy[k+1];
      rdy[k]    = ~main_v_q[k] | rdy[k+1];
    end
  end

  assign in_ready = rdy[0] & ~flush & ~rst;

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (rdy[k]) begin
        main_v_d[k] = src_v[k];
        main_d_d[k] = src_v[k] ? src_d[k] : NopVal;
      end
    end
  end
`endif

  always_comb begin
    count_d = count_q;
    unique case ({in_hs, out_hs})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        main_d_q[k] <= NopVal;
      end
`ifdef PIPE_ELASTIC_SKID_EN
      skid_v_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        skid_d_q[k] <= NopVal;
      end
`endif
    end else begin
      main_v_q <= main_v_d;
      count_q  <= count_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        main_d_q[k] <= main_d_d[k];
      end
`ifdef PIPE_ELASTIC_SKID_EN
      skid_v_q <= skid_v_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        skid_d_q[k] <= skid_d_d[k];
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: vector table, hand sequences and a queue scoreboard.
module tb_pipe_elastic_stage;

`ifdef PIPE_ELASTIC_SKID_EN
  localparam int Mult = 2;
`else
  localparam int Mult = 1;
`endif
  localparam int CapA = 2 * Mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_iv, a_ir, a_ov, a_or, a_fl;
  logic [31:0] a_id, a_od;
  logic [2:0]  a_cnt;
  logic        b_iv, b_ir, b_ov, b_or, b_fl;
  logic [31:0] b_id, b_od;
  logic [2:0]  b_cnt;
  logic        c_iv, c_ir, c_ov, c_or, c_fl;
  logic [7:0]  c_id, c_od;
  logic [2:0]  c_cnt;

  pipe_elastic_stage #(.WIDTH(32), .DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush(a_fl), .count(a_cnt)
  );
  pipe_elastic_stage #(.WIDTH(32), .DEPTH(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush(b_fl), .count(b_cnt)
  );
  pipe_elastic_stage #(.WIDTH(8), .DEPTH(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .flush(c_fl), .count(c_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_cnt;
    logic        e_ir;
  } vec_t;

  vec_t tbl [6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic [7:0] q[$];
  int         pushed;
  int         cyc;
  logic       prev_stall;
  logic [7:0] prev_od;
  logic [7:0] exp_c;

  initial begin
    // DEPTH=2 streaming with out_ready held high
    tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h13, 0, 1'b1};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 1'b0, 32'h13, 1, 1'b1};
    tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 32'h11, 2, 1'b1};
    tbl[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 2, 1'b1};
    tbl[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 1, 1'b1};
    tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h13, 0, 1'b1};

    rst = 1'b1;
    a_iv = 0; a_id = 0; a_or = 0; a_fl = 0;
    b_iv = 0; b_id = 0; b_or = 0; b_fl = 0;
    c_iv = 0; c_id = 0; c_or = 0; c_fl = 0;

    // Reset for two cycles
    @(negedge clk); a_iv = 1'b1; #1;
    chk("rst_ir_c0", a_ir, 0);
    @(negedge clk); #1;
    chk("rst_ir_c1", a_ir, 0);
    chk("rst_ov", a_ov, 0);
    chk("rst_od", a_od, 32'h13);
    chk("rst_cnt", a_cnt, 0);
    @(negedge clk); rst = 1'b0; a_iv = 1'b0; #1;
    chk("rst_ir_after", a_ir, 1);
    chk("rst_b_od", b_od, 32'h13);
    chk("rst_c_od", c_od, 8'h13);
    chk("rst_c_cnt", c_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_iv = tbl[i].iv; a_id = tbl[i].id; a_or = tbl[i].ordy; a_fl = 1'b0;
      #1;
      chk($sformatf("tbl%0d_ov", i), a_ov, tbl[i].e_ov);
      chk($sformatf("tbl%0d_od", i), a_od, tbl[i].e_od);
      chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_ir", i), a_ir, tbl[i].e_ir);
    end

    // Fill under backpressure, then drain in order
    for (int i = 0; i < CapA + 2; i++) begin
      @(negedge clk);
      a_or = 1'b0; a_iv = 1'b1;
      a_id = (i < CapA) ? 32'h11 * (i + 1) : 32'h11 * (CapA + 1);
      #1;
      chk($sformatf("full%0d_ir", i), a_ir, (i < CapA) ? 1 : 0);
      chk($sformatf("full%0d_cnt", i), a_cnt, (i < CapA) ? i : CapA);
      if (i >= 2) begin
        chk($sformatf("full%0d_ov", i), a_ov, 1);
        chk($sformatf("full%0d_od", i), a_od, 32'h11);
      end
    end
    for (int j = 0; j < CapA; j++) begin
      @(negedge clk);
      a_iv = 1'b0; a_or = 1'b1;
      #1;
      chk($sformatf("drain%0d_ov", j), a_ov, 1);
      chk($sformatf("drain%0d_od", j), a_od, 32'h11 * (j + 1));
      chk($sformatf("drain%0d_cnt", j), a_cnt, CapA - j);
    end
    @(negedge clk); a_or = 1'b0; #1;
    chk("drained_ov", a_ov, 0);
    chk("drained_od", a_od, 32'h13);
    chk("drained_cnt", a_cnt, 0);

    // DEPTH=3 flush with input and output both offered
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_iv = 1'b1; b_id = 32'hA1 + i; b_or = 1'b0;
      #1;
      chk($sformatf("bfill%0d_ir", i), b_ir, 1);
    end
    @(negedge clk);
    b_fl = 1'b1; b_iv = 1'b1; b_id = 32'hB0; b_or = 1'b1;
    #1;
    chk("flush_ir", b_ir, 0);
    chk("flush_ov", b_ov, 1);
    chk("flush_od", b_od, 32'hA1);
    chk("flush_cnt", b_cnt, 3);
    @(negedge clk);
    b_fl = 1'b0; b_iv = 1'b0; b_or = 1'b0;
    #1;
    chk("postflush_ov", b_ov, 0);
    chk("postflush_od", b_od, 32'h13);
    chk("postflush_cnt", b_cnt, 0);
    chk("postflush_ir", b_ir, 1);
    @(negedge clk);
    b_fl = 1'b1; b_iv = 1'b1; b_id = 32'hC0;
    #1;
    chk("eflush_ir", b_ir, 0);
    @(negedge clk);
    b_fl = 1'b0; b_iv = 1'b0;
    #1;
    chk("eflush_cnt", b_cnt, 0);
    chk("eflush_ov", b_ov, 0);

    // Reset while two entries are held under backpressure
    @(negedge clk); a_iv = 1'b1; a_id = 32'h55; a_or = 1'b0;
    @(negedge clk); a_id = 32'h66;
    @(negedge clk); a_iv = 1'b0; rst = 1'b1;
    #1;
    chk("mrst_ov_before", a_ov, 1);
    chk("mrst_cnt_before", a_cnt, 2);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mrst_ov", a_ov, 0);
    chk("mrst_od", a_od, 32'h13);
    chk("mrst_cnt", a_cnt, 0);
    chk("mrst_ir", a_ir, 1);

    // Random pushes on the 8-bit instance with alternating out_ready
    pushed = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_od = 8'h00;
    while ((pushed < 20 || q.size() > 0) && cyc < 400) begin
      @(negedge clk);
      c_or = (pushed < 20) ? ((cyc % 2) == 0) : 1'b1;
      c_iv = (pushed < 20) && ($urandom_range(0, 3) != 0);
      c_id = 8'($urandom);
      #1;
      chk("rnd_cnt", c_cnt, q.size());
      if (!c_ov) chk("rnd_bubble", c_od, 8'h13);
`ifdef PIPE_ELASTIC_SKID_EN
      if (c_ir) chk("rnd_ir_cap", (q.size() < 4) ? 1 : 0, 1);
`else
      chk("rnd_ir", c_ir, (q.size() < 2 || c_or) ? 1 : 0);
`endif
      if (prev_stall) begin
        chk("rnd_hold_ov", c_ov, 1);
        chk("rnd_hold_od", c_od, prev_od);
      end
      if (c_ov && c_or) begin
        chk("rnd_nodup", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          exp_c = q.pop_front();
          chk("rnd_order", c_od, exp_c);
        end
      end
      if (c_iv && c_ir) begin
        q.push_back(c_id);
        pushed++;
      end
      prev_stall = c_ov && !c_or;
      prev_od = c_od;
      cyc++;
    end
    chk("rnd_pushed", pushed, 20);
    chk("rnd_leftover", q.size(), 0);
    @(negedge clk); c_iv = 1'b0; c_or = 1'b0;
    #1;
    chk("rnd_end_ov", c_ov, 0);
    chk("rnd_end_od", c_od, 8'h13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
